// File: rtl/register_file_np.sv
// register_file_np
// Parametrised register file between the data bus and the ALU/instruction
// datapath: DEPTH entries of W bits, one write port, NR registered read ports.
// Each entry carries a "written" flag that is set by a write and cleared by
// reset or CLR. Reads are write-first: a read of the address being written on
// the same edge returns the new data.
//
// Ports:
//   CLKb  in   1      clock, rising edge
//   RSTb  in   1      asynchronous active-low reset
//   D     in   W      write data
//   ENW   in   1      write enable
//   WRA   in   AW     write address (>= DEPTH is ignored)
//   CLR   in   1      synchronous clear of all entries and flags (beats a write)
//   ENR   in   NR     per-port read enable
//   RDA   in   NR*AW  read addresses, port p at [p*AW +: AW]
//   Q     out  NR*W   registered read data, port p at [p*W +: W]
//   QV    out  NR     registered written flag of the entry read
//
// Optional feature (macro RF_ZERO_REG_EN): entry 0 is a hardwired zero
// register. It has no storage, ignores writes, never bypasses, and reads back
// as Q=0 with QV=1.

module register_file_np #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int NR    = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            CLKb,
    input  logic            RSTb,
    input  logic [W-1:0]    D,
    input  logic            ENW,
    input  logic [AW-1:0]   WRA,
    input  logic            CLR,
    input  logic [NR-1:0]   ENR,
    input  logic [NR*AW-1:0] RDA,
    output logic [NR*W-1:0] Q,
    output logic [NR-1:0]   QV
);

`ifdef RF_ZERO_REG_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    // Storage only exists for entries LO..DEPTH-1.
    logic [DEPTH-1:LO][W-1:0] mem;
    logic [DEPTH-1:LO]        written;

    logic          wr_hit;
    logic [W-1:0]  rd_data [NR];
    logic [NR-1:0] rd_valid;

    // A write only takes effect when it lands on a stored entry and no clear
    // is pending; out-of-range addresses simply match nothing.
    always_comb begin
        wr_hit = 1'b0;
        for (int i = LO; i < DEPTH; i++) begin
            if (WRA == AW'(i)) begin
                wr_hit = 1'b1;
            end
        end
        wr_hit = wr_hit & ENW & ~CLR;
    end

    // Next read value per port, as seen after this edge's write/clear.
    // Disabled ports, out-of-range addresses and clear all yield zero.
    always_comb begin
        for (int p = 0; p < NR; p++) begin
            rd_data[p]  = '0;
            rd_valid[p] = 1'b0;
            if (ENR[p] && !CLR) begin
`ifdef RF_ZERO_REG_EN
                if (RDA[p*AW +: AW] == '0) begin
                    rd_valid[p] = 1'b1;
                end
`endif
                if (wr_hit && (WRA == RDA[p*AW +: AW])) begin
                    rd_data[p]  = D;
                    rd_valid[p] = 1'b1;
                end else begin
                    for (int i = LO; i < DEPTH; i++) begin
                        if (RDA[p*AW +: AW] == AW'(i)) begin
                            rd_data[p]  = mem[i];
                            rd_valid[p] = written[i];
                        end
                    end
                end
            end
        end
    end

    // Storage, flags and output registers. CLR wins over a simultaneous write.
    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            mem     <= '0;
            written <= '0;
            Q       <= '0;
            QV      <= '0;
        end else begin
            if (CLR) begin
                mem     <= '0;
                written <= '0;
            end else if (wr_hit) begin
                for (int i = LO; i < DEPTH; i++) begin
                    if (WRA == AW'(i)) begin
                        mem[i]     <= D;
                        written[i] <= 1'b1;
                    end
                end
            end
            for (int p = 0; p < NR; p++) begin
                Q[p*W +: W] <= rd_data[p];
            end
            QV <= rd_valid;
        end
    end

endmodule

// File: tb/tb_register_file_np.sv
// tb_register_file_np
// Self-checking bench for register_file_np. Two instances: the default
// configuration (W=10, DEPTH=4, NR=2) and a wider one (W=16, DEPTH=5, NR=3)
// with a non-power-of-two depth. A small behavioural model per instance
// predicts each read, the prediction is queued when the stimulus is driven,
// and popped and compared once the registered outputs update.

module tb_register_file_np;

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;

    // Default instance
    logic [9:0]  d;
    logic        enw;
    logic [1:0]  wra;
    logic        clr;
    logic [1:0]  enr;
    logic [3:0]  rda;
    logic [19:0] q;
    logic [1:0]  qv;

    // Wide instance
    logic [15:0] s_d;
    logic        s_enw;
    logic [2:0]  s_wra;
    logic        s_clr;
    logic [2:0]  s_enr;
    logic [8:0]  s_rda;
    logic [47:0] s_q;
    logic [2:0]  s_qv;

    register_file_np u_dut (
        .CLKb (clk),
        .RSTb (rstb),
        .D    (d),
        .ENW  (enw),
        .WRA  (wra),
        .CLR  (clr),
        .ENR  (enr),
        .RDA  (rda),
        .Q    (q),
        .QV   (qv)
    );

    register_file_np #(.W(16), .DEPTH(5), .NR(3)) u_dut_wide (
        .CLKb (clk),
        .RSTb (rstb),
        .D    (s_d),
        .ENW  (s_enw),
        .WRA  (s_wra),
        .CLR  (s_clr),
        .ENR  (s_enr),
        .RDA  (s_rda),
        .Q    (s_q),
        .QV   (s_qv)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state for each instance
    logic [9:0]  ma [4];
    logic [3:0]  mwa;
    logic [15:0] ms [5];
    logic [4:0]  mws;

    // Scoreboards: {q, qv} expected after the next edge
    logic [21:0] sb_a [$];
    logic [50:0] sb_s [$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModels();
        for (int i = 0; i < 4; i++) ma[i] = '0;
        for (int i = 0; i < 5; i++) ms[i] = '0;
        mwa = '0;
        mws = '0;
    endtask

    // Drive one cycle on the default instance, predict, then compare.
    task automatic applyStimulus(input string tag, input logic e, input logic [1:0] wa,
                                 input logic [9:0] dd, input logic c, input logic [1:0] en,
                                 input logic [1:0] a0, input logic [1:0] a1);
        logic [9:0]  eq [2];
        logic [1:0]  ev;
        logic [1:0]  ra [2];
        logic [21:0] exp_v;
        enw = e; wra = wa; d = dd; clr = c; enr = en; rda = {a1, a0};
        if (c) begin
            for (int i = 0; i < 4; i++) ma[i] = '0;
            mwa = '0;
        end else if (e && !(ZERO && wa == 2'd0)) begin
            ma[wa]  = dd;
            mwa[wa] = 1'b1;
        end
        ra[0] = a0;
        ra[1] = a1;
        for (int p = 0; p < 2; p++) begin
            eq[p] = '0;
            ev[p] = 1'b0;
            if (en[p] && !c) begin
                if (ZERO && ra[p] == 2'd0) begin
                    ev[p] = 1'b1;
                end else begin
                    eq[p] = ma[ra[p]];
                    ev[p] = mwa[ra[p]];
                end
            end
        end
        sb_a.push_back({eq[1], eq[0], ev});
        @(posedge clk);
        #1;
        exp_v = sb_a.pop_front();
        checkOutput({tag, " q"},  64'(q),  64'(exp_v[21:2]));
        checkOutput({tag, " qv"}, 64'(qv), 64'(exp_v[1:0]));
    endtask

    // Same for the wide instance, where addresses 5..7 are out of range.
    task automatic applySweep(input string tag, input logic e, input logic [2:0] wa,
                              input logic [15:0] dd, input logic c, input logic [2:0] en,
                              input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        logic [15:0] eq [3];
        logic [2:0]  ev;
        logic [2:0]  ra [3];
        logic [50:0] exp_v;
        s_enw = e; s_wra = wa; s_d = dd; s_clr = c; s_enr = en; s_rda = {a2, a1, a0};
        if (c) begin
            for (int i = 0; i < 5; i++) ms[i] = '0;
            mws = '0;
        end else if (e && wa < 3'd5 && !(ZERO && wa == 3'd0)) begin
            ms[wa]  = dd;
            mws[wa] = 1'b1;
        end
        ra[0] = a0;
        ra[1] = a1;
        ra[2] = a2;
        for (int p = 0; p < 3; p++) begin
            eq[p] = '0;
            ev[p] = 1'b0;
            if (en[p] && !c && ra[p] < 3'd5) begin
                if (ZERO && ra[p] == 3'd0) begin
                    ev[p] = 1'b1;
                end else begin
                    eq[p] = ms[ra[p]];
                    ev[p] = mws[ra[p]];
                end
            end
        end
        sb_s.push_back({eq[2], eq[1], eq[0], ev});
        @(posedge clk);
        #1;
        exp_v = sb_s.pop_front();
        checkOutput({tag, " q"},  64'(s_q),  64'(exp_v[50:3]));
        checkOutput({tag, " qv"}, 64'(s_qv), 64'(exp_v[2:0]));
    endtask

    initial begin
        rstb  = 1'b0;
        d     = '0; enw = 1'b0; wra = '0; clr = 1'b0; enr = '0; rda = '0;
        s_d   = '0; s_enw = 1'b0; s_wra = '0; s_clr = 1'b0; s_enr = '0; s_rda = '0;
        resetModels();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset q",       64'(q),    64'd0);
        checkOutput("reset qv",      64'(qv),   64'd0);
        checkOutput("reset wide q",  64'(s_q),  64'd0);
        checkOutput("reset wide qv", 64'(s_qv), 64'd0);
        @(negedge clk);
        rstb = 1'b1;

        // Fill every entry, read some back, then reset asynchronously mid-cycle
        for (int a = 0; a < 4; a++) begin
            applyStimulus("fill", 1'b1, 2'(a), 10'h3FF, 1'b0, 2'b00, 2'd0, 2'd0);
        end
        applyStimulus("fill_rd", 1'b0, 2'd0, 10'h000, 1'b0, 2'b11, 2'd0, 2'd1);
        #3;
        rstb = 1'b0;
        #1;
        checkOutput("async_rst q",  64'(q),  64'd0);
        checkOutput("async_rst qv", 64'(qv), 64'd0);
        resetModels();
        #2;
        rstb = 1'b1;
        applyStimulus("post_rst_rd01", 1'b0, 2'd0, 10'h000, 1'b0, 2'b11, 2'd0, 2'd1);
        applyStimulus("post_rst_rd23", 1'b0, 2'd0, 10'h000, 1'b0, 2'b11, 2'd2, 2'd3);

        // Basic write then dual read
        applyStimulus("wr2",   1'b1, 2'd2, 10'h155, 1'b0, 2'b00, 2'd0, 2'd0);
        applyStimulus("wr3",   1'b1, 2'd3, 10'h2AA, 1'b0, 2'b00, 2'd0, 2'd0);
        applyStimulus("rd23",  1'b0, 2'd0, 10'h000, 1'b0, 2'b11, 2'd2, 2'd3);

        // Write-first bypass on both ports, then with one port disabled
        applyStimulus("bypass_both", 1'b1, 2'd1, 10'h0F0, 1'b0, 2'b11, 2'd1, 2'd1);
        applyStimulus("bypass_p0",   1'b1, 2'd1, 10'h00F, 1'b0, 2'b01, 2'd1, 2'd1);

        // Clear beats a simultaneous write; nothing survives
        applyStimulus("clr_prio", 1'b1, 2'd0, 10'h123, 1'b1, 2'b01, 2'd0, 2'd0);
        applyStimulus("clr_rd0",  1'b0, 2'd0, 10'h000, 1'b0, 2'b11, 2'd0, 2'd2);

        // Entry 0: ordinary register, or hardwired zero with the macro
        applyStimulus("wr0",        1'b1, 2'd0, 10'h3FF, 1'b0, 2'b00, 2'd0, 2'd0);
        applyStimulus("rd0",        1'b0, 2'd0, 10'h000, 1'b0, 2'b01, 2'd0, 2'd0);
        applyStimulus("bypass0",    1'b1, 2'd0, 10'h0AB, 1'b0, 2'b10, 2'd0, 2'd0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          10'($urandom_range(0, 1023)), ($urandom_range(0, 7) == 0),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)));
        end

        // Wide instance: out-of-range writes and reads
        applySweep("sw_wr4",  1'b1, 3'd4, 16'hBEEF, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
        applySweep("sw_wr6",  1'b1, 3'd6, 16'h1234, 1'b0, 3'b001, 3'd6, 3'd0, 3'd0);
        applySweep("sw_rd",   1'b0, 3'd0, 16'h0000, 1'b0, 3'b110, 3'd0, 3'd7, 3'd4);
        applySweep("sw_byp",  1'b1, 3'd2, 16'hCAFE, 1'b0, 3'b111, 3'd2, 3'd4, 3'd2);
        for (int n = 0; n < 40; n++) begin
            applySweep("sw_rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       16'($urandom_range(0, 65535)), ($urandom_range(0, 7) == 0),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_np.md
Name: register_file_np

Overview:
- Parametrised successor to the 4x10-bit, 1-write/2-read datapath register file.
- Generalised to DEPTH entries of W bits with NR independent read ports.
- Adds registered read outputs, write-first bypass, per-entry written flags, synchronous bulk clear and async reset.
- Sits between the data bus and the ALU/instruction datapath; reads feed operand latches and writes come from the bus.

Parameters:
- W, 10, data width in bits.
- DEPTH, 4, number of register entries (2 or more; need not be a power of 2).
- NR, 2, number of read ports (1 or more).
- AW, $clog2(DEPTH), address width (derived; not overridden by users).

Ports:
- CLKb  input  1  clock; all state updates on its rising edge.
- RSTb  input  1  asynchronous active-low reset.
- D  input  W  write data from the data bus.
- ENW  input  1  write enable.
- WRA  input  AW  write address.
- CLR  input  1  synchronous clear of all entries and flags.
- ENR  input  NR  per-port read enable; bit p belongs to port p.
- RDA  input  NR*AW  read addresses; port p uses bits [p*AW +: AW].
- Q  output  NR*W  read data; port p uses bits [p*W +: W].
- QV  output  NR  per-port flag: the entry read had been written since the last reset/clear.

Behaviour:
- Reset (RSTb low, asynchronous, no clock needed): all entries = 0, all written flags = 0, Q = 0, QV = 0. State is held while RSTb is low. First update is on the first rising edge after RSTb deasserts.
  - Reset mid-write: the write is lost.
- Write:
  - On a rising edge with ENW=1, CLR=0 and WRA < DEPTH: entry[WRA] <= D and written[WRA] <= 1.
  - WRA >= DEPTH: write ignored, no state change.
- Clear: on a rising edge with CLR=1, all entries and flags go to 0.
  - CLR has priority over a simultaneous write; the write is dropped.
  - Q/QV for the same edge see the cleared values: reads return 0 with QV=0.
- Read: registered, 1-cycle latency. On each rising edge, for each port p independently:
  - ENR[p]=1 and RDA_p < DEPTH: Q_p <= value of entry[RDA_p] after this edge's write/clear; QV_p <= written flag after this edge.
  - ENR[p]=0: Q_p <= 0 and QV_p <= 0. A disabled port drives zero; it does not hold its last value.
  - RDA_p >= DEPTH: Q_p <= 0 and QV_p <= 0.
- Write-first bypass: if ENW=1, CLR=0 and WRA == RDA_p on the same edge, Q_p <= D and QV_p <= 1.
- Multiple ports may read the same address in one cycle; all get identical data.
- No internal state machine beyond the storage array. Q/QV are pure registers, so there is no combinational path from inputs to outputs.
- No arithmetic. Widths are exact; D is stored unmodified.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- When defined:
  - Entry 0 is hardwired to zero; writes to address 0 are ignored with no flag change.
  - Reads of address 0 with the port enabled return Q=0 and QV=1.
  - Bypass never applies to address 0.
  - Storage for entry 0 is not synthesised.
- When undefined: entry 0 behaves like every other entry.

Test Plan:
- Reset: drive RSTb=0 asynchronously mid-cycle after filling entries with 0x3FF -> Q=0 and QV=0 immediately. After release, reading all addresses -> Q=0, QV=0.
- Basic write/read: write 0x155 to addr 2, then 0x2AA to addr 3. Next cycle ENR=2'b11, port0 reads addr 2, port1 reads addr 3 -> one edge later Q0=0x155, Q1=0x2AA, QV=2'b11.
- Bypass/collision: same edge ENW=1, WRA=1, D=0x0F0, port0 reads addr 1, port1 reads addr 1 -> after the edge Q0=Q1=0x0F0, QV=2'b11. Port with ENR=0 on that edge -> Q=0.
- Clear priority: entries hold data; assert CLR=1 and ENW=1 (WRA=0, D=0x123) on the same edge with port0 reading addr 0 -> Q0=0, QV0=0. Subsequent read of addr 0 -> 0, unwritten.
- Parameter sweep: W=16, DEPTH=5, NR=3. Write 0xBEEF to addr 4; attempt write to addr 6 -> ignored. Port2 reads addr 4 -> 0xBEEF, QV=1. Port1 reads addr 7 -> Q=0, QV=0.
- RF_ZERO_REG_EN: with macro defined, write 0x3FF to addr 0 and read it back -> Q=0, QV=1. Without macro -> Q=0x3FF, QV=1.
